// File: rtl/led_panel_frame_buffer.sv
// Double-buffered LED panel pixel store with per-channel gamma tables and frame-boundary bank swap.
// Optional build macro LEDPANEL_GAMMA_BYPASS_EN adds a per-request gamma_bypass input.
module led_panel_frame_buffer #(
    parameter int ADDR_LINES = 10,
    parameter int COLOR_BITS = 8,
    parameter int CHANNELS   = 3
) (
    input  logic                           clock,
    input  logic                           reset_n,
    input  logic [ADDR_LINES-1:0]          wr_addr,
    input  logic [CHANNELS*COLOR_BITS-1:0] wr_data,
    input  logic                           wr_en,
    input  logic [ADDR_LINES-1:0]          rd_addr,
    input  logic                           rd_en,
    output logic [CHANNELS*COLOR_BITS-1:0] rd_data,
    output logic                           rd_valid,
    input  logic                           swap_req,
    input  logic                           frame_end,
    output logic                           swap_pending,
    output logic                           swap_ack,
    output logic                           front_bank,
    input  logic [COLOR_BITS-1:0]          gamma_addr,
    input  logic [CHANNELS*COLOR_BITS-1:0] gamma_wdata,
    input  logic                           gamma_we,
    input  logic                           gamma_re,
`ifdef LEDPANEL_GAMMA_BYPASS_EN
    input  logic                           gamma_bypass,
`endif
    output logic [CHANNELS*COLOR_BITS-1:0] gamma_rdata,
    output logic                           gamma_rvalid
);

    localparam int PIX_W  = CHANNELS * COLOR_BITS;
    localparam int DEPTH  = 1 << ADDR_LINES;
    localparam int GDEPTH = 1 << COLOR_BITS;

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PENDING = 1'b1
    } swap_state_e;

    // Gamma entries are stored XORed with their own index, so an all-zero
    // power-up image reads back as the identity curve.
    logic [PIX_W-1:0]      pix_mem   [0:2*DEPTH-1]                = '{default: '0};
    logic [COLOR_BITS-1:0] gamma_mem [0:CHANNELS-1][0:GDEPTH-1]   = '{default: '0};

    logic [1:0]       rst_sync_q;
    logic             rst_n_s;
    swap_state_e      state_q;
    logic             front_bank_q;
    logic             swap_pending_q;
    logic             swap_done_q;
    logic             swap_ack_q;
    logic             s1_valid_q;
    logic [PIX_W-1:0] s1_pix_q;
    logic [PIX_W-1:0] rd_data_q;
    logic [PIX_W-1:0] rd_data_d;
    logic             rd_valid_q;
    logic [PIX_W-1:0] gamma_rdata_q;
    logic [PIX_W-1:0] gamma_rd_s;
    logic [PIX_W-1:0] lut_pix_s;
    logic             gamma_rvalid_q;

    // Reset synchroniser: assertion is immediate, release is aligned to the clock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_q[1];

    // Pixel RAM write port: always targets the bank not being displayed.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            pix_mem[{~front_bank_q, wr_addr}] <= wr_data;
        end
    end

    // Gamma RAM write port, all channel tables at once.
    always_ff @(posedge clock) begin
        if (gamma_we) begin
            for (int c = 0; c < CHANNELS; c++) begin
                gamma_mem[c][gamma_addr] <= gamma_wdata[c*COLOR_BITS +: COLOR_BITS] ^ gamma_addr;
            end
        end
    end

    // Per-channel gamma lookups for the pipeline and the host read port.
    always_comb begin
        lut_pix_s  = '0;
        gamma_rd_s = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            lut_pix_s[c*COLOR_BITS +: COLOR_BITS] =
                gamma_mem[c][s1_pix_q[c*COLOR_BITS +: COLOR_BITS]] ^ s1_pix_q[c*COLOR_BITS +: COLOR_BITS];
            gamma_rd_s[c*COLOR_BITS +: COLOR_BITS] = gamma_mem[c][gamma_addr] ^ gamma_addr;
        end
    end

    // Stage-2 data selection.
    always_comb begin
`ifdef LEDPANEL_GAMMA_BYPASS_EN
        if (gamma_bypass) begin
            rd_data_d = s1_pix_q;
        end else begin
            rd_data_d = lut_pix_s;
        end
`else
        rd_data_d = lut_pix_s;
`endif
    end

    // Two-stage read pipeline; the bank is captured with the address at stage 1.
    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            s1_valid_q <= 1'b0;
            s1_pix_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_en;
            s1_pix_q   <= pix_mem[{front_bank_q, rd_addr}];
            rd_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                rd_data_q <= rd_data_d;
            end else begin
                rd_data_q <= rd_data_q;
            end
        end
    end

    // Host gamma read port, read-before-write.
    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            gamma_rdata_q  <= '0;
            gamma_rvalid_q <= 1'b0;
        end else if (gamma_re) begin
            gamma_rdata_q  <= gamma_rd_s;
            gamma_rvalid_q <= 1'b1;
        end else begin
            gamma_rdata_q  <= '0;
            gamma_rvalid_q <= 1'b0;
        end
    end

    // Swap state machine; swap_ack trails the bank toggle by one cycle.
    always_ff @(posedge clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_q        <= ST_IDLE;
            front_bank_q   <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
            swap_ack_q     <= 1'b0;
        end else begin
            swap_ack_q  <= swap_done_q;
            swap_done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (swap_req && frame_end) begin
                        front_bank_q <= ~front_bank_q;
                        swap_done_q  <= 1'b1;
                    end else if (swap_req) begin
                        state_q        <= ST_PENDING;
                        swap_pending_q <= 1'b1;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PENDING: begin
                    if (frame_end) begin
                        front_bank_q   <= ~front_bank_q;
                        swap_done_q    <= 1'b1;
                        state_q        <= ST_IDLE;
                        swap_pending_q <= 1'b0;
                    end else begin
                        state_q <= ST_PENDING;
                    end
                end
                default: begin
                    state_q        <= ST_IDLE;
                    swap_pending_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data      = rd_data_q;
    assign rd_valid     = rd_valid_q;
    assign gamma_rdata  = gamma_rdata_q;
    assign gamma_rvalid = gamma_rvalid_q;
    assign swap_pending = swap_pending_q;
    assign swap_ack     = swap_ack_q;
    assign front_bank   = front_bank_q;

endmodule
